// File: rtl/matrix_pkg.sv
// Shared types, 2-of-5 weights and the 5x7 digit font for the dot-matrix scan controller.
package matrix_pkg;

  localparam int ROWS = 7;

  // 2-of-5 weights for code bits [4:0]
  localparam logic [3:0] WT_B4 = 4'd7;
  localparam logic [3:0] WT_B3 = 4'd4;
  localparam logic [3:0] WT_B2 = 4'd2;
  localparam logic [3:0] WT_B1 = 4'd1;
  localparam logic [3:0] WT_B0 = 4'd0;
  localparam logic [19:0] WEIGHTS = {WT_B4, WT_B3, WT_B2, WT_B1, WT_B0};

  typedef logic [2:0] row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  // FONT[digit][row-1]; bit 4 is the leftmost column
  localparam logic [4:0] FONT [10][7] = '{
    '{5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110},
    '{5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110},
    '{5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111},
    '{5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110},
    '{5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010},
    '{5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110},
    '{5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110},
    '{5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000},
    '{5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110},
    '{5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100}
  };

  function automatic logic [4:0] glyph(input logic [3:0] digit, input row_t row);
    logic [4:0] g;
    g = '0;
    if (digit <= 4'd9 && row != 3'd0) g = FONT[digit][row - 3'd1];
    return g;
  endfunction

endpackage

// File: rtl/two_of_five_dec.sv
// Combinational 2-of-5 digit decoder (weights 7,4,2,1,0; 7+4 encodes zero).
module two_of_five_dec
  import matrix_pkg::*;
(
  input  logic [4:0] code,
  output logic [3:0] digit,
  output logic       valid
);

  always_comb begin
    logic [3:0] sum;
    logic [2:0] ones;
    sum  = '0;
    ones = '0;
    for (int i = 0; i < 5; i++) begin
      if (code[i]) begin
        ones = ones + 3'd1;
        sum  = sum + WEIGHTS[i*4 +: 4];
      end
    end
    valid = (ones == 3'd2);
    digit = '0;
    if (valid && sum != 4'd11) digit = sum;
  end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Double-buffered 2-of-5 digit row-scan sequencer for a 5x7 dot-matrix display.
// Optional MATRIX_SCAN_BLANK_EN adds a blank slot after row 7 (8-slot frame).
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] code,
  output logic       ready,
  output logic       ch1,
  output logic       ch2,
  output logic       ch3,
  output logic       v,
  output logic [4:0] col,
  output logic       err,
  output logic       frame_done
);

  scan_state_t      state, state_nx;
  row_t             row, row_nx, ch_q, ch_nx;
  logic [CNT_W-1:0] count;
  logic             tick, swap, wrap;
  logic [4:0]       pending, display, disp_nx, col_nx;
  logic             pend_full, v_nx, err_nx;
  logic [3:0]       dec_digit;
  logic             dec_valid;

  assign tick  = (count == CNT_W'(DIV - 1));
  assign ready = !pend_full;
  assign {ch1, ch2, ch3} = ch_q;

  two_of_five_dec u_dec (
    .code  (disp_nx),
    .digit (dec_digit),
    .valid (dec_valid)
  );

  always_comb begin
    state_nx = state;
    row_nx   = row;
    swap     = 1'b0;
    wrap     = 1'b0;
    if (tick) begin
      case (state)
        IDLE: if (pend_full) begin
          swap     = 1'b1;
          state_nx = SCAN;
          row_nx   = 3'd1;
        end
        SCAN: if (row == row_t'(ROWS)) begin
`ifdef MATRIX_SCAN_BLANK_EN
          state_nx = BLANK;
          row_nx   = '0;
`else
          wrap     = 1'b1;
          row_nx   = 3'd1;
`endif
        end else begin
          row_nx = row + 3'd1;
        end
        BLANK: begin
          wrap     = 1'b1;
          state_nx = SCAN;
          row_nx   = 3'd1;
        end
        default: state_nx = IDLE;
      endcase
    end
    // Swapping only at the wrap keeps every glyph starting at row 1
    if (wrap && pend_full) swap = 1'b1;
    disp_nx = swap ? pending : display;

    ch_nx  = '0;
    v_nx   = 1'b0;
    col_nx = '0;
    err_nx = 1'b0;
    case (state_nx)
      SCAN: begin
        ch_nx  = row_nx;
        v_nx   = dec_valid;
        col_nx = dec_valid ? glyph(dec_digit, row_nx) : 5'b0;
        err_nx = !dec_valid;
      end
      BLANK:   err_nx = !dec_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
    end else begin
      state <= state_nx;
      row   <= row_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      pending    <= '0;
      pend_full  <= 1'b0;
      display    <= '0;
      ch_q       <= '0;
      v          <= 1'b0;
      col        <= '0;
      err        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      count <= tick ? '0 : count + CNT_W'(1);
      if (load && ready) begin
        pending   <= code;
        pend_full <= 1'b1;
      end else if (swap) begin
        pend_full <= 1'b0;
      end
      display    <= disp_nx;
      frame_done <= wrap;
      if (tick) begin
        ch_q <= ch_nx;
        v    <= v_nx;
        col  <= col_nx;
        err  <= err_nx;
      end
    end
  end

endmodule
